// File: rtl/synchronous_input_debounce_controller.sv
// synchronous_input_debounce_controller: synchronizes and debounces one raw input into a level, edge pulses and a press count
module synchronous_input_debounce_controller #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   IN,
  output logic                   OUT,
  output logic                   PRESS_PULSE,
  output logic                   RELEASE_PULSE,
  output logic [COUNT_WIDTH-1:0] PRESS_COUNT
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic out_q, out_d, press_q, press_d, release_q, release_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic in_s;
  assign in_s = sync_q[SYNC_STAGES-1];
  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], IN};
  // the stability counter only advances in the two WAIT states; any transition clears it
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    out_d     = out_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    count_d   = count_q;
    case (state_q)
      IDLE: state_d = in_s ? WAIT_PRESS : IDLE;
      WAIT_PRESS:
        if (!in_s) state_d = IDLE;
        else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          out_d   = 1'b1;
          press_d = 1'b1;
          count_d = count_q + 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      PRESSED: state_d = in_s ? PRESSED : WAIT_RELEASE;
      WAIT_RELEASE:
        if (in_s) state_d = PRESSED;
        else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          out_d     = 1'b0;
          release_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      out_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= '0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      press_q   <= press_d;
      release_q <= release_d;
      count_q   <= count_d;
    end
  end
  assign OUT           = out_q;
  assign PRESS_PULSE   = press_q;
  assign RELEASE_PULSE = release_q;
  assign PRESS_COUNT   = count_q;
endmodule

// File: tb/tb_synchronous_input_debounce_controller.sv
// tb_synchronous_input_debounce_controller: random and directed stimulus scored against a run-length reference model
module tb_synchronous_input_debounce_controller;
  localparam int S  = 2;
  localparam int D  = 4;
  localparam int CW = 8;
  logic CLK = 1'b0, RESET = 1'b1, IN = 1'b0;
  logic OUT, PRESS_PULSE, RELEASE_PULSE;
  logic [CW-1:0] PRESS_COUNT;
  typedef struct packed {
    logic          out;
    logic          pp;
    logic          rp;
    logic [CW-1:0] cnt;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, cyc_n = 0;
  bit m_hist[$];
  bit m_lvl;
  int m_run;
  logic [CW-1:0] m_cnt;

  synchronous_input_debounce_controller #(
    .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .COUNT_WIDTH(CW)
  ) dut (
    .CLK(CLK), .RESET(RESET), .IN(IN), .OUT(OUT),
    .PRESS_PULSE(PRESS_PULSE), .RELEASE_PULSE(RELEASE_PULSE), .PRESS_COUNT(PRESS_COUNT)
  );

  always #30 CLK = ~CLK;

  // level flips once the delayed input has disagreed with it for D+1 consecutive edges
  task automatic model_step(input bit rst, input bit in_v, output exp_t e);
    bit ins;
    e.pp = 1'b0;
    e.rp = 1'b0;
    if (rst) begin
      m_hist.delete();
      repeat (S) m_hist.push_back(1'b0);
      m_lvl = 1'b0;
      m_run = 0;
      m_cnt = '0;
    end else begin
      ins = m_hist.pop_front();
      m_hist.push_back(in_v);
      if (ins != m_lvl) begin
        m_run++;
        if (m_run == D + 1) begin
          m_lvl = !m_lvl;
          m_run = 0;
          if (m_lvl) begin
            e.pp = 1'b1;
            m_cnt = m_cnt + 1'b1;
          end else e.rp = 1'b1;
        end
      end else m_run = 0;
    end
    e.out = m_lvl;
    e.cnt = m_cnt;
  endtask

  task automatic drive(input bit rst, input bit in_v, input bit glitch = 1'b0);
    exp_t e;
    @(negedge CLK);
    RESET = rst;
    IN    = in_v;
    model_step(rst, in_v, e);
    sb.push_back(e);
    if (glitch) begin
      #5 IN = 1'b1;
      #20 IN = in_v;
    end
  endtask

  task automatic hold(input bit in_v, input int n);
    repeat (n) drive(1'b0, in_v);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      cyc_n++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({OUT, PRESS_PULSE, RELEASE_PULSE, PRESS_COUNT} !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d: got out=%b press=%b release=%b count=%0d, want out=%b press=%b release=%b count=%0d",
                   cyc_n, OUT, PRESS_PULSE, RELEASE_PULSE, PRESS_COUNT, e.out, e.pp, e.rp, e.cnt);
        end
        checks++;
        if (PRESS_PULSE === 1'b1 && RELEASE_PULSE === 1'b1) begin
          errors++;
          $display("FAIL both_pulses cycle %0d: got press=1 release=1, want at most one high", cyc_n);
        end
      end
    end
  end

  initial begin
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    hold(1'b0, 3);
    hold(1'b1, 20);
    hold(1'b0, 20);
    hold(1'b1, 1);
    drive(1'b0, 1'b0, 1'b1);
    hold(1'b1, 3);
    hold(1'b0, 10);
    hold(1'b1, 2);
    hold(1'b0, 1);
    hold(1'b1, 10);
    hold(1'b0, 12);
    hold(1'b1, 10);
    drive(1'b1, 1'b1);
    hold(1'b1, 12);
    hold(1'b0, 12);
    for (int i = 0; i < 258; i++) begin
      hold(1'b1, int'($urandom_range(6, 9)));
      hold(1'b0, int'($urandom_range(6, 9)));
    end
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 40) == 0) drive(1'b1, 1'($urandom_range(0, 1)));
      else hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 8)));
    end
    hold(1'b0, 10);
    @(posedge CLK);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
